// File: rtl/a5_pkg.sv
// A5/1 keystream generator: shared constants and state encoding.
package a5_pkg;

  localparam int R1_LEN = 19;
  localparam int R2_LEN = 22;
  localparam int R3_LEN = 23;

  localparam logic [R1_LEN-1:0] R1_TAPS = 19'h72000;
  localparam logic [R2_LEN-1:0] R2_TAPS = 22'h300000;
  localparam logic [R3_LEN-1:0] R3_TAPS = 23'h700080;

  localparam int R1_CBIT = 8;
  localparam int R2_CBIT = 10;
  localparam int R3_CBIT = 10;

  localparam int LOAD_LEN   = 86;
  localparam int KSLEN_DEF  = 228;
  localparam int MIXLEN_DEF = 101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MIX,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/a5_keystream_if.sv
// A5/1 keystream request and output stream bundle.
interface a5_keystream_if;

  logic        start;
  logic [63:0] key;
  logic [21:0] frame;
  logic        ks_ready;
  logic        ks_valid;
  logic        ks_bit;
  logic        ks_last;
  logic        busy;
  logic        done;

  modport master (
    output start, key, frame, ks_ready,
    input  ks_valid, ks_bit, ks_last, busy, done
  );

  modport slave (
    input  start, key, frame, ks_ready,
    output ks_valid, ks_bit, ks_last, busy, done
  );

endinterface

// File: rtl/a5_lfsr.sv
// One A5/1 LFSR: unconditional shift in load mode, majority-gated otherwise.
module a5_lfsr
  import a5_pkg::*;
#(
  parameter int          LEN  = R1_LEN,
  parameter logic [LEN-1:0] TAPS = R1_TAPS,
  parameter int          CBIT = R1_CBIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic load_mode,
  input  logic in_bit,
  input  logic maj,
  input  logic hold,
  output logic msb,
  output logic clk_bit
);

  logic [LEN-1:0] r_q, r_d;
  logic           fb;
  logic           shift;

  always_comb begin
    fb    = ^(r_q & TAPS) ^ in_bit;
    shift = !hold && (load_mode || (r_q[CBIT] == maj));
    r_d   = r_q;
    if (clr)
      r_d = '0;
    else if (shift)
      r_d = {r_q[LEN-2:0], fb};
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_q <= '0;
    else
      r_q <= r_d;
  end

  assign msb     = r_q[LEN-1];
  assign clk_bit = r_q[CBIT];

endmodule

// File: rtl/a5_keystream.sv
// A5/1 keystream generator: key/frame load, mixing, then a
// valid/ready bit stream of KSLEN bits per frame.
module a5_keystream
  import a5_pkg::*;
#(
  parameter int KSLEN  = KSLEN_DEF,
  parameter int MIXLEN = MIXLEN_DEF
) (
  input logic         clock,
  input logic         reset,
  a5_keystream_if.slave ks
);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] key_q, key_d;
  logic [21:0] frame_q, frame_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;

  logic hs, maj, in_bit, load_mode, hold, clr;
  logic c1, c2, c3, m1, m2, m3;

  always_comb begin
    hs        = valid_q && ks.ks_ready;
    maj       = (c1 & c2) | (c1 & c3) | (c2 & c3);
    load_mode = (state_q == ST_LOAD);
    clr       = (state_q == ST_IDLE) && ks.start;
    in_bit    = 1'b0;
    if (load_mode) begin
      if (cnt_q < 8'd64)
        in_bit = key_q[cnt_q[5:0]];
      else
        in_bit = frame_q[5'(cnt_q - 8'd64)];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    frame_d = frame_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    hold    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (ks.start) begin
          key_d   = ks.key;
          frame_d = ks.frame;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        hold  = 1'b0;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(LOAD_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_MIX;
        end
      end
      ST_MIX: begin
        hold  = 1'b0;
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(MIXLEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
          valid_d = 1'b1;
          last_d  = (KSLEN == 1);
        end
      end
      ST_RUN: begin
        valid_d = 1'b1;
        last_d  = last_q;
        // the final bit is handed over without clocking the registers
        if (hs && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (hs) begin
          hold   = 1'b0;
          cnt_d  = cnt_q + 8'd1;
          last_d = (cnt_q + 8'd1 == 8'(KSLEN - 1));
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      frame_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      frame_q <= frame_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  a5_lfsr #(.LEN(R1_LEN), .TAPS(R1_TAPS), .CBIT(R1_CBIT)) u_r1 (
    .clock(clock), .reset(reset), .clr(clr),
    .load_mode(load_mode), .in_bit(in_bit), .maj(maj), .hold(hold),
    .msb(m1), .clk_bit(c1)
  );

  a5_lfsr #(.LEN(R2_LEN), .TAPS(R2_TAPS), .CBIT(R2_CBIT)) u_r2 (
    .clock(clock), .reset(reset), .clr(clr),
    .load_mode(load_mode), .in_bit(in_bit), .maj(maj), .hold(hold),
    .msb(m2), .clk_bit(c2)
  );

  a5_lfsr #(.LEN(R3_LEN), .TAPS(R3_TAPS), .CBIT(R3_CBIT)) u_r3 (
    .clock(clock), .reset(reset), .clr(clr),
    .load_mode(load_mode), .in_bit(in_bit), .maj(maj), .hold(hold),
    .msb(m3), .clk_bit(c3)
  );

  assign ks.ks_valid = valid_q;
  assign ks.ks_bit   = valid_q & (m1 ^ m2 ^ m3);
  assign ks.ks_last  = last_q;
  assign ks.busy     = (state_q != ST_IDLE);
  assign ks.done     = done_q;

endmodule

// File: tb/tb_a5_keystream.sv
// Scoreboard bench for a5_keystream against a bit-level A5/1 model.
module tb_a5_keystream;

  localparam int KSL = 228;
  localparam int MIX = 101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  a5_keystream_if ifc ();

  a5_keystream #(.KSLEN(KSL), .MIXLEN(MIX)) dut (
    .clock(clk),
    .reset(rst),
    .ks(ifc)
  );

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails = 0;
  int   done_cnt = 0;
  int   done_base = 0;
  int   n_pop = 0;
  bit   rand_rdy = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  function automatic logic [KSL-1:0] model(input logic [63:0] k,
                                           input logic [21:0] f);
    logic [18:0]    a;
    logic [21:0]    b;
    logic [22:0]    c;
    logic [KSL-1:0] ks;
    logic           ib, mj;
    a = '0; b = '0; c = '0; ks = '0;
    for (int i = 0; i < 86; i++) begin
      if (i < 64) ib = k[i];
      else        ib = f[i-64];
      a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13] ^ ib};
      b = {b[20:0], b[21] ^ b[20] ^ ib};
      c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7] ^ ib};
    end
    for (int s = 0; s < MIX + KSL; s++) begin
      if (s >= MIX) ks[s-MIX] = a[18] ^ b[21] ^ c[22];
      if (s < MIX + KSL - 1) begin
        mj = (a[8] & b[10]) | (a[8] & c[10]) | (b[10] & c[10]);
        if (a[8] == mj)  a = {a[17:0], a[18] ^ a[17] ^ a[16] ^ a[13]};
        if (b[10] == mj) b = {b[20:0], b[21] ^ b[20]};
        if (c[10] == mj) c = {c[21:0], c[22] ^ c[21] ^ c[20] ^ c[7]};
      end
    end
    return ks;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [63:0] k, input logic [21:0] f);
    logic [KSL-1:0] v;
    v = model(k, f);
    for (int j = 0; j < KSL; j++)
      exp_q.push_back('{b: v[j], l: (j == KSL - 1)});
    done_base = done_cnt;
    n_pop = 0;
    ifc.key   = k;
    ifc.frame = f;
    ifc.start = 1'b1;
    tick(1);
    ifc.start = 1'b0;
    ifc.key   = {$urandom, $urandom};
    ifc.frame = 22'($urandom);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      tick(1);
      n++;
    end
    tick(3);
    check({tag, "_done"}, 64'(done_cnt - done_base), 1);
    check({tag, "_busy"}, ifc.busy, 0);
    check({tag, "_nbits"}, 64'(n_pop), KSL);
    check({tag, "_left"}, 64'(exp_q.size()), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, ifc.ks_valid, 0);
    check({tag, "_bit"}, ifc.ks_bit, 0);
    check({tag, "_last"}, ifc.ks_last, 0);
    check({tag, "_busy"}, ifc.busy, 0);
    check({tag, "_donep"}, ifc.done, 0);
  endtask

  task automatic pulse_reset(input string tag);
    int d0;
    d0 = done_cnt;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_idle(tag);
    exp_q.delete();
    n_pop = 0;
    tick(5);
    check({tag, "_nodone"}, 64'(done_cnt), 64'(d0));
  endtask

  initial begin : ready_drv
    ifc.ks_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.ks_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin : monitor
    bit   pst;
    logic pb;
    exp_t e;
    pst = 0;
    pb  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pst = 0;
      end else begin
        if (pst && ifc.ks_valid)
          check("stall_hold", ifc.ks_bit, pb);
        if (ifc.ks_valid && ifc.ks_ready) begin
          if (exp_q.size() == 0) begin
            check("bit_expected", 64'(exp_q.size() != 0), 1);
          end else begin
            e = exp_q.pop_front();
            check("ks_bit", ifc.ks_bit, e.b);
            check("ks_last", ifc.ks_last, e.l);
            n_pop++;
          end
        end
        pst = ifc.ks_valid && !ifc.ks_ready;
        pb  = ifc.ks_bit;
        if (ifc.done) done_cnt++;
      end
    end
  end

  initial begin : main
    int lat;
    int n;
    ifc.start = 1'b0;
    ifc.key   = '0;
    ifc.frame = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    check_idle("reset");

    start_frame(64'h0, 22'h0);
    wait_done("zero", 1200);

    tick(1);
    start_frame(64'h1223456789ABCDEF, 22'h134);
    lat = 1;
    while (!ifc.ks_valid && lat < 400) begin
      tick(1);
      lat++;
    end
    check("latency", 64'(lat), 188);
    wait_done("known", 1200);

    tick(1);
    rand_rdy = 1;
    start_frame({$urandom, $urandom}, 22'($urandom));
    wait_done("rand_rdy", 3000);
    rand_rdy = 0;
    tick(2);

    start_frame({$urandom, $urandom}, 22'($urandom));
    tick(86 + 40);
    check("mix_busy", ifc.busy, 1);
    pulse_reset("rst_mix");
    start_frame({$urandom, $urandom}, 22'($urandom));
    wait_done("after_mix", 1200);

    tick(1);
    start_frame({$urandom, $urandom}, 22'($urandom));
    n = 0;
    while (n_pop < 100 && n < 1000) begin
      tick(1);
      n++;
    end
    check("run_bit100", 64'(n_pop), 100);
    pulse_reset("rst_run");
    start_frame(64'h1223456789ABCDEF, 22'h134);
    wait_done("after_run", 1200);

    tick(1);
    rst = 1'b1;
    ifc.start = 1'b1;
    ifc.key = {$urandom, $urandom};
    tick(1);
    rst = 1'b0;
    ifc.start = 1'b0;
    tick(1);
    check("rst_prio_busy", ifc.busy, 0);

    start_frame({$urandom, $urandom}, 22'($urandom));
    tick(20);
    ifc.start = 1'b1;
    ifc.key = {$urandom, $urandom};
    tick(1);
    ifc.start = 1'b0;
    tick(200);
    ifc.start = 1'b1;
    ifc.frame = 22'($urandom);
    tick(1);
    ifc.start = 1'b0;
    n = 0;
    while (!ifc.ks_last && n < 1000) begin
      tick(1);
      n++;
    end
    ifc.start = 1'b1;
    tick(2);
    ifc.start = 1'b0;
    wait_done("ignored", 1200);
    tick(3);
    check("ignored_one_done", 64'(done_cnt - done_base), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
